// File: rtl/bcd2bin.sv
// ============================================================================
// Module   : bcd2bin
// Brief    : Sequential BCD-to-binary converter using reverse double dabble.
//            One right shift per clock, with a subtract-3 on any BCD nibble
//            that is >= 8 after the shift. Valid/ready on both sides.
//            Optional macro BCD2BIN_CHECK_EN flags non-decimal input nibbles
//            at accept time and returns err=1, bin_out=0 without converting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2bin #(
    parameter int DIGITS = 4,
    parameter int BW     = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW-1:0]         bin_out,
    output logic                  err
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [DW-1:0]  bcd_reg;
    logic [BW-1:0]  bin_reg;
    logic [CW-1:0]  cnt;

    logic [DW-1:0]  bcd_shift;
    logic [BW-1:0]  bin_shift;
    logic [DW-1:0]  bcd_corr;
    logic           bad_input;
    logic           accept;

    assign accept = in_valid && (state == IDLE);

    // Shift the whole {bcd, bin} working register right by one bit
    always_comb begin
        {bcd_shift, bin_shift} = {bcd_reg, bin_reg} >> 1;
    end

    // Per-nibble correction: a nibble whose MSB is set (>= 8) loses 3
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        assign bcd_corr[4*i +: 4] = bcd_shift[4*i + 3] ? (bcd_shift[4*i +: 4] - 4'd3)
                                                       : bcd_shift[4*i +: 4];
    end

`ifdef BCD2BIN_CHECK_EN
    logic err_reg;

    // Flag any input nibble outside 0..9
    always_comb begin
        bad_input = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_input = 1'b1;
            end
        end
    end

    // Error flag is captured at accept and held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= bad_input;
        end
    end

    assign err = err_reg;
`else
    assign bad_input = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a bad input skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = bad_input ? DONE : CONV;
                end
            end
            CONV: begin
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working register and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (bad_input) begin
                bcd_reg <= '0;
                bin_reg <= '0;
                cnt     <= '0;
            end else begin
                bcd_reg <= bcd_in;
                bin_reg <= '0;
                cnt     <= CW'(BW);
            end
        end else if (state == CONV) begin
            bcd_reg <= bcd_corr;
            bin_reg <= bin_shift;
            cnt     <= cnt - CW'(1);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign bin_out   = bin_reg;

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin.sv
// ============================================================================
// Module   : tb_bcd2bin
// Brief    : Self-checking bench for bcd2bin: directed cases, handshake
//            stalls, back-to-back throughput, reset abort and random values
//            compared against a decimal-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd2bin;

    localparam int DIGITS = 4;
    localparam int BW     = 14;
    localparam int DW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] bcd_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] bin_out;
    logic          err;

    int n_asserts = 0;
    int n_fail    = 0;

    bcd2bin #(.DIGITS(DIGITS), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: decimal value -> packed BCD via plain arithmetic
    function automatic logic [DW-1:0] to_bcd(input int value);
        logic [DW-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one input, check latency/result, stall 'hold' cycles, handshake out
    task automatic run_conv(input logic [DW-1:0] bcd, input int exp_val,
                            input int hold, input bit exp_err);
        int lat;
        int guard;
        logic [BW-1:0] b0;
        logic e0;
        guard = 0;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        bcd_in   = bcd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bcd_in   = DW'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), exp_err ? 32'd0 : 32'(BW));
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("bin_out", 32'(bin_out), 32'(exp_val));
        chk("err", 32'(err), 32'(exp_err));
        b0 = bin_out;
        e0 = err;
        for (int k = 0; k < hold; k++) begin
            bcd_in   = DW'($urandom);
            in_valid = 1'b1;
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_bin_out", 32'(bin_out), 32'(b0));
            chk("hold_err", 32'(err), 32'(e0));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // Output handshake; in_valid stays high and must not be taken this edge
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int t;
        int seen;
        int v;

        // Reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed values
        run_conv(16'h1234, 1234, 0, 1'b0);
        run_conv(16'h9999, 9999, 0, 1'b0);
        run_conv(16'h0000, 0, 0, 1'b0);
        run_conv(16'h0815, 815, 5, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        bcd_in    = 16'h9999;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        bcd_in = 16'h0000;
        t    = 0;
        seen = 0;
        while (t < 40) begin
            if (out_valid) begin
                seen++;
                chk("b2b_first_bin", 32'(bin_out), 32'd9999);
            end
            if (in_ready) begin
                tick();
                t++;
                break;
            end
            tick();
            t++;
        end
        chk("b2b_accept_spacing", 32'(t), 32'(BW + 2));
        chk("b2b_first_valid_count", 32'(seen), 32'd1);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 40) begin
            tick();
            t++;
        end
        chk("b2b_second_latency", 32'(t), 32'(BW));
        chk("b2b_second_bin", 32'(bin_out), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 32'(in_ready), 32'd1);

`ifdef BCD2BIN_CHECK_EN
        run_conv(16'h12A4, 0, 2, 1'b1);
`endif
        run_conv(16'h0042, 42, 0, 1'b0);

        // Reset abort during CONV
        bcd_in   = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_bin_out", 32'(bin_out), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        run_conv(16'h0100, 100, 0, 1'b0);

        // Random values against decimal reference
        for (int n = 0; n < 300; n++) begin
            v = int'($urandom_range(0, 9999));
            run_conv(to_bcd(v), v, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
